// File: rtl/ssm_bitstream_mux_if.sv
// Handshake bundle between the SSM encoders / block-size source, the substream
// multiplexer and the downstream bitstream writer.
interface ssm_bitstream_mux_if #(
  parameter int WORD_W = 128
);
  logic [3:0]          ssm_wr_vld;
  logic [4*WORD_W-1:0] ssm_wr_data;
  logic [3:0]          ssm_wr_rdy;
  logic                blk_vld;
  logic [31:0]         blk_se_size;
  logic                blk_rdy;
  logic                slice_end;
  logic                mux_vld;
  logic [WORD_W-1:0]   mux_data;
  logic                mux_rdy;
  logic                err_uflow;
  logic                err_stall;

  modport master (
    output ssm_wr_vld, ssm_wr_data, blk_vld, blk_se_size, slice_end, mux_rdy,
    input  ssm_wr_rdy, blk_rdy, mux_vld, mux_data, err_uflow, err_stall
  );

  modport slave (
    input  ssm_wr_vld, ssm_wr_data, blk_vld, blk_se_size, slice_end, mux_rdy,
    output ssm_wr_rdy, blk_rdy, mux_vld, mux_data, err_uflow, err_stall
  );
endinterface

// File: rtl/ssm_bitstream_mux.sv
// Encoder-side substream multiplexer: buffers words from 4 SSM encoders and emits
// them in the exact order the decoder's per-SSM bit-balance model requests them.
module ssm_bitstream_mux #(
  parameter int WORD_W      = 128,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_SE_SIZE = 142,
  parameter int BAL_W       = 10
) (
  input  logic               clk,
  input  logic               rstn,
  ssm_bitstream_mux_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BAL_W-1:0] WORD_INC = BAL_W'(WORD_W);
  localparam logic [BAL_W-1:0] MAX_SE   = BAL_W'(MAX_SE_SIZE);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t            state_r, state_nx;
  logic [3:0]        req_mask_r, mask_nx;
  logic [1:0]        drn_ptr_r, drn_ptr_nx;
  logic              slice_pend_r;
  logic              err_uflow_r, err_stall_r;
  logic [7:0]        se_r  [4];
  logic [BAL_W-1:0]  bal_r [4];

  logic [WORD_W-1:0] mem_r  [4][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_r [4];
  logic [PTR_W-1:0]  rptr_r [4];
  logic [CNT_W-1:0]  cnt_r  [4];

  logic [3:0]        push_s, pop_s, nonempty_s, new_mask_s, cur_bit_s;
  logic [BAL_W-1:0]  se_ext_s [4];
  logic [1:0]        cur_s, sel_s;
  logic              mux_vld_s, fire_s, uflow_any_s;
  logic              blk_acc_s, upd_bal_s, drain_done_s, stall_s;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // FIFO status, request selection and output handshake decode
  always_comb begin
    uflow_any_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nonempty_s[i]     = (cnt_r[i] != {CNT_W{1'b0}});
      push_s[i]         = bus.ssm_wr_vld[i] && (cnt_r[i] != FULL_CNT);
      bus.ssm_wr_rdy[i] = (cnt_r[i] != FULL_CNT);
      new_mask_s[i]     = (bal_r[i] < MAX_SE);
      se_ext_s[i]       = {{(BAL_W-8){1'b0}}, se_r[i]};
      uflow_any_s       = uflow_any_s | (se_ext_s[i] > bal_r[i]);
    end
    cur_s     = lowest_set(req_mask_r);
    cur_bit_s = 4'b0001 << cur_s;
    sel_s     = (state_r == ST_DRAIN) ? drn_ptr_r : cur_s;
    if (state_r == ST_EMIT) begin
      mux_vld_s = (req_mask_r != 4'b0000) && nonempty_s[sel_s];
    end else if (state_r == ST_DRAIN) begin
      mux_vld_s = nonempty_s[sel_s];
    end else begin
      mux_vld_s = 1'b0;
    end
    fire_s = mux_vld_s && bus.mux_rdy;
    for (int i = 0; i < 4; i++) begin
      pop_s[i] = fire_s && (sel_s == 2'(i));
    end
  end

  assign bus.mux_vld   = mux_vld_s;
  assign bus.mux_data  = mux_vld_s ? mem_r[sel_s][rptr_r[sel_s]] : {WORD_W{1'b0}};
  assign bus.blk_rdy   = (state_r == ST_IDLE);
  assign bus.err_uflow = err_uflow_r;
  assign bus.err_stall = err_stall_r;

  // FSM next-state: a new block always wins over a pending slice drain
  always_comb begin
    state_nx     = state_r;
    mask_nx      = req_mask_r;
    drn_ptr_nx   = drn_ptr_r;
    blk_acc_s    = 1'b0;
    upd_bal_s    = 1'b0;
    drain_done_s = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.blk_vld) begin
          blk_acc_s = 1'b1;
          mask_nx   = new_mask_s;
          state_nx  = ST_EMIT;
        end else if (slice_pend_r) begin
          drn_ptr_nx = 2'd0;
          state_nx   = ST_DRAIN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (req_mask_r == 4'b0000) begin
          state_nx = ST_UPDATE;
        end else if (!nonempty_s[cur_s]) begin
          stall_s = 1'b1;
        end else if (bus.mux_rdy) begin
          mask_nx = req_mask_r & ~cur_bit_s;
          if ((req_mask_r & ~cur_bit_s) == 4'b0000) begin
            state_nx = ST_UPDATE;
          end else begin
            state_nx = ST_EMIT;
          end
        end else begin
          state_nx = ST_EMIT;
        end
      end
      ST_UPDATE: begin
        upd_bal_s = 1'b1;
        state_nx  = ST_IDLE;
      end
      ST_DRAIN: begin
        if (nonempty_s == 4'b0000) begin
          drain_done_s = 1'b1;
          state_nx     = ST_IDLE;
        end else if (!nonempty_s[drn_ptr_r] || bus.mux_rdy) begin
          drn_ptr_nx = drn_ptr_r + 2'd1;
        end else begin
          drn_ptr_nx = drn_ptr_r;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      req_mask_r <= 4'b0000;
      drn_ptr_r  <= 2'd0;
    end else begin
      state_r    <= state_nx;
      req_mask_r <= mask_nx;
      drn_ptr_r  <= drn_ptr_nx;
    end
  end

  // Decoder-model balances, latched block sizes, pending drain and sticky errors
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slice_pend_r <= 1'b0;
      err_uflow_r  <= 1'b0;
      err_stall_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bal_r[i] <= {BAL_W{1'b0}};
        se_r[i]  <= 8'd0;
      end
    end else begin
      if (drain_done_s) begin
        slice_pend_r <= bus.slice_end;
      end else if (bus.slice_end) begin
        slice_pend_r <= 1'b1;
      end
      if (stall_s) begin
        err_stall_r <= 1'b1;
      end
      if (upd_bal_s && uflow_any_s) begin
        err_uflow_r <= 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (blk_acc_s) begin
          se_r[i] <= bus.blk_se_size[i*8 +: 8];
        end
        if (drain_done_s) begin
          bal_r[i] <= {BAL_W{1'b0}};
        end else if (upd_bal_s) begin
          // A syntax element larger than the balance clamps to empty
          bal_r[i] <= (se_ext_s[i] > bal_r[i]) ? {BAL_W{1'b0}} : bal_r[i] - se_ext_s[i];
        end else if (pop_s[i] && (state_r == ST_EMIT)) begin
          bal_r[i] <= bal_r[i] + WORD_INC;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        wptr_r[i] <= {PTR_W{1'b0}};
        rptr_r[i] <= {PTR_W{1'b0}};
        cnt_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_s[i]) begin
          wptr_r[i] <= wptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rptr_r[i] <= rptr_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // FIFO storage; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_s[i]) begin
        mem_r[i][wptr_r[i]] <= bus.ssm_wr_data[i*WORD_W +: WORD_W];
      end
    end
  end
endmodule
